// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready register slice. Breaks the combinational ready path
// (in_ready is a flop) while sustaining one word per cycle; a word arriving
// while the output is stalled is parked in a skid register.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    upstream payload, sampled on in_valid & in_ready
//   in_valid   upstream word present
//   in_ready   slice can accept a word this cycle (registered)
//   out_data   downstream payload (main register)
//   out_valid  main register holds a valid word (registered)
//   out_ready  downstream accepts out_data this cycle
//   occupancy  stored words, 0..2 (registered)
module pipe_skid_buffer #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [1:0]            occupancy
);

   localparam int unsigned OCC_W = 2;

   // Encoding equals the number of stored words.
   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] main_q;
   logic [DATA_WIDTH-1:0] main_nxt;
   logic [DATA_WIDTH-1:0] skid_q;
   logic [DATA_WIDTH-1:0] skid_nxt;
   logic                  in_ready_nxt;
   logic                  out_valid_nxt;
   logic [OCC_W-1:0]      occupancy_nxt;
   logic                  xfer_in_c;
   logic                  xfer_out_c;

   // Handshakes use only registered flags, so no input-to-output comb path.
   assign xfer_in_c  = in_valid & in_ready;
   assign xfer_out_c = out_valid & out_ready;
   assign out_data   = main_q;

   // State, datapath and registered status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         occupancy <= '0;
      end else begin
         state_q   <= state_nxt;
         main_q    <= main_nxt;
         skid_q    <= skid_nxt;
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         occupancy <= occupancy_nxt;
      end
   end

   // Next-state, datapath loads and next values of the status flags.
   always_comb begin
      state_nxt = state_q;
      main_nxt  = main_q;
      skid_nxt  = skid_q;

      unique case (state_q)
         EMPTY: begin
            if (xfer_in_c) begin
               main_nxt  = in_data;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (xfer_in_c && xfer_out_c) begin
               main_nxt = in_data;
            end else if (xfer_in_c) begin
               skid_nxt  = in_data;
               state_nxt = FULL;
            end else if (xfer_out_c) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            // Skid word always follows the main word out.
            if (xfer_out_c) begin
               main_nxt  = skid_q;
               state_nxt = BUSY;
            end
         end
         default: state_nxt = EMPTY;
      endcase

      in_ready_nxt  = (state_nxt != FULL);
      out_valid_nxt = (state_nxt != EMPTY);
      occupancy_nxt = OCC_W'(state_nxt);
   end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Scoreboard bench for pipe_skid_buffer: the driver pushes each accepted word,
// a monitor pops and compares on every output transfer and checks that a
// stalled output holds steady.
module tb_pipe_skid_buffer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] occupancy;

   logic [7:0] sb[$];
   int         checks = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   pipe_skid_buffer #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Called at posedge+1; returns at the next posedge+1.
   task automatic drive(input logic v, input logic [7:0] d, input logic r, output logic acc);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sb.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_occupancy", 32'(occupancy), 32'd0);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
   endtask

   // Monitor: compare on transfer out, and check stability while stalled.
   initial begin
      logic       stall_q = 1'b0;
      logic [7:0] held_q = '0;
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (stall_q) begin
               chk("stall_valid_hold", 32'(out_valid), 32'd1);
               chk("stall_data_hold", 32'(out_data), 32'(held_q));
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  exp = sb.pop_front();
                  chk("out_data", 32'(out_data), 32'(exp));
               end
            end
         end
         stall_q = rst_n && out_valid && !out_ready;
         held_q  = out_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a;
      int   acc_cnt;
      int   cyc;
      logic [7:0] d;

      // 1. Reset with in_valid asserted.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h99;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("rel_in_ready_high", 32'(in_ready), 32'd1);
      chk("rel_no_capture", 32'(out_valid), 32'd0);
      chk("rel_occupancy", 32'(occupancy), 32'd0);
      in_valid = 1'b0;

      // 2. Streaming 0x01..0x10.
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 8'(i), 1'b1, a);
         chk("stream_occupancy", 32'(occupancy), 32'd1);
         chk("stream_latency", 32'(out_data), 32'(i));
      end
      drain();

      // 3. Stall and skid.
      drive(1'b1, 8'hA5, 1'b0, a);
      drive(1'b1, 8'h3C, 1'b0, a);
      chk("skid_occupancy", 32'(occupancy), 32'd2);
      chk("skid_in_ready", 32'(in_ready), 32'd0);
      chk("skid_out_data", 32'(out_data), 32'hA5);
      drive(1'b1, 8'hEE, 1'b0, a);
      chk("full_ignores_in", 32'(a), 32'd0);
      chk("full_occupancy", 32'(occupancy), 32'd2);
      drive(1'b0, 8'h00, 1'b1, a);
      chk("unskid_occupancy", 32'(occupancy), 32'd1);
      chk("unskid_in_ready", 32'(in_ready), 32'd1);
      chk("unskid_out_data", 32'(out_data), 32'h3C);
      drive(1'b0, 8'h00, 1'b1, a);
      chk("unskid_empty", 32'(occupancy), 32'd0);

      // 5. Back-to-back in&out alternating 0xFF/0x00.
      drive(1'b1, 8'hFF, 1'b1, a);
      for (int i = 0; i < 10; i++) begin
         d = (i % 2 == 0) ? 8'h00 : 8'hFF;
         drive(1'b1, d, 1'b1, a);
         chk("alt_occupancy", 32'(occupancy), 32'd1);
         chk("alt_out_data", 32'(out_data), 32'(d));
      end
      drain();

      // 4. Random in_valid/out_ready, 1000 words.
      acc_cnt = 0;
      cyc     = 0;
      while (acc_cnt < 1000 && cyc < 20000) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), a);
         if (a) acc_cnt++;
         cyc++;
      end
      chk("random_accepted", 32'(acc_cnt), 32'd1000);
      drain();
      chk("random_sb_empty", 32'(sb.size()), 32'd0);

      // 6. Asynchronous reset while FULL.
      drive(1'b1, 8'h11, 1'b0, a);
      drive(1'b1, 8'h22, 1'b0, a);
      chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd0);
      chk("async_rst_occupancy", 32'(occupancy), 32'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 8'h55, 1'b1, a);
      chk("post_rst_first", 32'(out_data), 32'h55);
      drive(1'b1, 8'h66, 1'b1, a);
      drain();
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
